// File: rtl/pipe_ctrl_decoder_if.sv
// Control-decoder bus: the ID-stage instruction inputs plus the staged
// EX/MEM/WB control outputs of pipe_ctrl_decoder.
//   master : instruction source / pipeline consumer (drives instr/valid/flush)
//   slave  : the decoder (drives stall and all staged control outputs)
interface pipe_ctrl_decoder_if #(
    parameter int ALU_OP_W = 3
);
    logic [31:0]         instr_i;
    logic                id_valid_i;
    logic                flush_i;
    logic                stall_o;
    logic [ALU_OP_W-1:0] ex_alu_op_o;
    logic                ex_alusrc_o;
    logic [1:0]          ex_regdst_o;
    logic                ex_branch_o;
    logic [1:0]          ex_branch_type_o;
    logic                ex_jump_o;
    logic                ex_illegal_o;
    logic                mem_memread_o;
    logic                mem_memwrite_o;
    logic                wb_regwrite_o;
    logic [1:0]          wb_memtoreg_o;

    modport master (
        output instr_i, id_valid_i, flush_i,
        input  stall_o, ex_alu_op_o, ex_alusrc_o, ex_regdst_o, ex_branch_o,
               ex_branch_type_o, ex_jump_o, ex_illegal_o, mem_memread_o,
               mem_memwrite_o, wb_regwrite_o, wb_memtoreg_o
    );

    modport slave (
        input  instr_i, id_valid_i, flush_i,
        output stall_o, ex_alu_op_o, ex_alusrc_o, ex_regdst_o, ex_branch_o,
               ex_branch_type_o, ex_jump_o, ex_illegal_o, mem_memread_o,
               mem_memwrite_o, wb_regwrite_o, wb_memtoreg_o
    );
endinterface

// File: rtl/pipe_ctrl_decoder.sv
// Pipelined control decoder for a 5-stage MIPS-like core.
// Decodes the ID opcode into a control bundle, carries it through the
// ID/EX, EX/MEM and MEM/WB registers, and raises a combinational load-use
// stall request.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset, clears every stage to a bubble
//   bus   : pipe_ctrl_decoder_if.slave (instr/valid/flush in, controls out)
// ALU_OP_W must be at least 3; ALU opcodes are zero-extended to it.
module pipe_ctrl_decoder #(
    parameter int ALU_OP_W  = 3,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_ctrl_decoder_if.slave  bus
);
    typedef struct packed {
        logic                regWrite;
        logic [ALU_OP_W-1:0] aluOp;
        logic                aluSrc;
        logic [1:0]          regDst;
        logic                branch;
        logic [1:0]          branchType;
        logic                jump;
        logic                memRead;
        logic                memWrite;
        logic [1:0]          memToReg;
        logic                illegal;
    } ctrlBundle_t;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic [1:0] memToReg;
    } exMemCtrl_t;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] memToReg;
    } memWbCtrl_t;

    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    ctrlBundle_t bundle_s;
    logic        stall_s;

    ctrlBundle_t idEx_r;
    logic [4:0]  idExRt_r;
    exMemCtrl_t  exMem_r;
    memWbCtrl_t  memWb_r;

    assign op_s = bus.instr_i[31:26];
    assign rs_s = bus.instr_i[25:21];
    assign rt_s = bus.instr_i[20:16];

    // Opcode decode into the control bundle; unknown opcodes flag illegal.
    always_comb begin
        bundle_s = '0;
        case (op_s)
            6'd0: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.regDst   = 2'b01;
            end
            6'd1: begin
                bundle_s.branch     = 1'b1;
                bundle_s.branchType = 2'b11;
                bundle_s.aluOp      = ALU_OP_W'(3'b010);
            end
            6'd2: begin
                bundle_s.jump = 1'b1;
            end
            6'd3: begin
                bundle_s.jump     = 1'b1;
                bundle_s.regWrite = 1'b1;
                bundle_s.regDst   = 2'b10;
                bundle_s.memToReg = 2'b10;
            end
            6'd4: begin
                bundle_s.branch     = 1'b1;
                bundle_s.branchType = 2'b00;
                bundle_s.aluOp      = ALU_OP_W'(3'b001);
            end
            6'd5: begin
                bundle_s.branch     = 1'b1;
                bundle_s.branchType = 2'b01;
                bundle_s.aluOp      = ALU_OP_W'(3'b001);
            end
            6'd6: begin
                bundle_s.branch     = 1'b1;
                bundle_s.branchType = 2'b10;
                bundle_s.aluOp      = ALU_OP_W'(3'b111);
            end
            6'd8: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b011);
            end
            6'd9: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b100);
            end
            6'd13: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b101);
            end
            6'd15: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b110);
            end
            6'd35: begin
                bundle_s.regWrite = 1'b1;
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b011);
                bundle_s.memRead  = 1'b1;
                bundle_s.memToReg = 2'b01;
            end
            6'd43: begin
                bundle_s.aluSrc   = 1'b1;
                bundle_s.aluOp    = ALU_OP_W'(3'b011);
                bundle_s.memWrite = 1'b1;
            end
            default: begin
                bundle_s.illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load in EX targets a register the ID instruction
    // reads. Register 0 is hard-wired, so it never creates a dependency.
    always_comb begin
        stall_s = 1'b0;
        if (HAZARD_EN && bus.id_valid_i && idEx_r.memRead &&
            (idExRt_r != 5'd0) &&
            ((idExRt_r == rs_s) || (idExRt_r == rt_s))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // ID/EX register: flush, stall or an empty ID slot all insert a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idEx_r   <= '0;
            idExRt_r <= 5'd0;
        end else if (bus.flush_i || stall_s || !bus.id_valid_i) begin
            idEx_r   <= '0;
            idExRt_r <= 5'd0;
        end else begin
            idEx_r   <= bundle_s;
            idExRt_r <= rt_s;
        end
    end

    // EX/MEM register: a flush kills the instruction currently in EX.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exMem_r <= '0;
        end else if (bus.flush_i) begin
            exMem_r <= '0;
        end else begin
            exMem_r <= '{memRead:  idEx_r.memRead,
                         memWrite: idEx_r.memWrite,
                         regWrite: idEx_r.regWrite,
                         memToReg: idEx_r.memToReg};
        end
    end

    // MEM/WB register: always advances.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memWb_r <= '0;
        end else begin
            memWb_r <= '{regWrite: exMem_r.regWrite,
                         memToReg: exMem_r.memToReg};
        end
    end

    assign bus.stall_o          = stall_s;
    assign bus.ex_alu_op_o      = idEx_r.aluOp;
    assign bus.ex_alusrc_o      = idEx_r.aluSrc;
    assign bus.ex_regdst_o      = idEx_r.regDst;
    assign bus.ex_branch_o      = idEx_r.branch;
    assign bus.ex_branch_type_o = idEx_r.branchType;
    assign bus.ex_jump_o        = idEx_r.jump;
    assign bus.ex_illegal_o     = idEx_r.illegal;
    assign bus.mem_memread_o    = exMem_r.memRead;
    assign bus.mem_memwrite_o   = exMem_r.memWrite;
    assign bus.wb_regwrite_o    = memWb_r.regWrite;
    assign bus.wb_memtoreg_o    = memWb_r.memToReg;
endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed self-checking bench for pipe_ctrl_decoder.
module tb_pipe_ctrl_decoder;
    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    pipe_ctrl_decoder_if #(.ALU_OP_W(3)) bus ();

    pipe_ctrl_decoder #(.ALU_OP_W(3), .HAZARD_EN(1'b1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // {alu_op, alusrc, regdst, branch, branch_type, jump, illegal}
    function automatic logic [10:0] exVec();
        return {bus.ex_alu_op_o, bus.ex_alusrc_o, bus.ex_regdst_o, bus.ex_branch_o,
                bus.ex_branch_type_o, bus.ex_jump_o, bus.ex_illegal_o};
    endfunction

    // Every output: {stall, ex vector, memread, memwrite, regwrite, memtoreg}
    function automatic logic [17:0] allVec();
        return {bus.stall_o, exVec(), bus.mem_memread_o, bus.mem_memwrite_o,
                bus.wb_regwrite_o, bus.wb_memtoreg_o};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic flush);
        bus.instr_i    = instr;
        bus.id_valid_i = valid;
        bus.flush_i    = flush;
    endtask

    logic [5:0]  tblOp  [12];
    logic [10:0] tblExp [12];

    initial begin
        checks = 0;
        errors = 0;
        tblOp[0]  = 6'd0;  tblExp[0]  = 11'b000_0_01_0_00_0_0;
        tblOp[1]  = 6'd1;  tblExp[1]  = 11'b010_0_00_1_11_0_0;
        tblOp[2]  = 6'd4;  tblExp[2]  = 11'b001_0_00_1_00_0_0;
        tblOp[3]  = 6'd5;  tblExp[3]  = 11'b001_0_00_1_01_0_0;
        tblOp[4]  = 6'd6;  tblExp[4]  = 11'b111_0_00_1_10_0_0;
        tblOp[5]  = 6'd2;  tblExp[5]  = 11'b000_0_00_0_00_1_0;
        tblOp[6]  = 6'd8;  tblExp[6]  = 11'b011_1_00_0_00_0_0;
        tblOp[7]  = 6'd9;  tblExp[7]  = 11'b100_1_00_0_00_0_0;
        tblOp[8]  = 6'd13; tblExp[8]  = 11'b101_1_00_0_00_0_0;
        tblOp[9]  = 6'd15; tblExp[9]  = 11'b110_1_00_0_00_0_0;
        tblOp[10] = 6'd63; tblExp[10] = 11'b000_0_00_0_00_0_1;
        tblOp[11] = 6'd43; tblExp[11] = 11'b011_1_00_0_00_0_0;

        // Reset state with a load presented in ID
        rst_i = 1'b0;
        drive(mk(6'd35, 5'd1, 5'd5), 1'b1, 1'b0);
        #2;
        check("reset_outputs", 32'(allVec()), 32'd0);
        #5;
        rst_i = 1'b1;

        // lw latency: EX, MEM, WB
        step();
        check("lw_ex", 32'(exVec()), 32'(11'b011_1_00_0_00_0_0));
        drive(32'h0, 1'b0, 1'b0);
        step();
        check("lw_mem_read", 32'(bus.mem_memread_o), 32'd1);
        step();
        check("lw_wb", 32'({bus.wb_regwrite_o, bus.wb_memtoreg_o}), 32'(3'b1_01));
        step();

        // Load-use: lw rt=5 then add rs=5
        drive(mk(6'd35, 5'd2, 5'd5), 1'b1, 1'b0);
        step();
        drive(mk(6'd0, 5'd5, 5'd3), 1'b1, 1'b0);
        #1;
        check("loaduse_stall", 32'(bus.stall_o), 32'd1);
        bus.id_valid_i = 1'b0;
        #1;
        check("loaduse_invalid_nostall", 32'(bus.stall_o), 32'd0);
        bus.id_valid_i = 1'b1;
        step();
        check("loaduse_bubble", 32'(exVec()), 32'd0);
        check("loaduse_stall_released", 32'(bus.stall_o), 32'd0);
        check("loaduse_mem_advances", 32'(bus.mem_memread_o), 32'd1);
        step();
        check("loaduse_add_issues", 32'(exVec()), 32'(11'b000_0_01_0_00_0_0));

        // lw rt=0 never stalls
        drive(mk(6'd35, 5'd2, 5'd0), 1'b1, 1'b0);
        step();
        drive(mk(6'd0, 5'd0, 5'd0), 1'b1, 1'b0);
        #1;
        check("rt0_nostall", 32'(bus.stall_o), 32'd0);

        // lw rt in ID rt field also stalls
        drive(mk(6'd35, 5'd2, 5'd9), 1'b1, 1'b0);
        step();
        drive(mk(6'd43, 5'd1, 5'd9), 1'b1, 1'b0);
        #1;
        check("loaduse_rt_stall", 32'(bus.stall_o), 32'd1);
        drive(32'h0, 1'b0, 1'b0);
        step();
        step();
        step();

        // Flush: sw in ID, lw in EX
        drive(mk(6'd35, 5'd2, 5'd7), 1'b1, 1'b0);
        step();
        drive(mk(6'd43, 5'd1, 5'd2), 1'b1, 1'b1);
        step();
        check("flush_ex", 32'(exVec()), 32'd0);
        check("flush_mem", 32'({bus.mem_memread_o, bus.mem_memwrite_o}), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        step();
        check("flush_mem_nowrite", 32'(bus.mem_memwrite_o), 32'd0);
        check("flush_wb_noregwrite", 32'(bus.wb_regwrite_o), 32'd0);

        // Flush wins over a pending stall
        drive(mk(6'd35, 5'd2, 5'd6), 1'b1, 1'b0);
        step();
        drive(mk(6'd0, 5'd6, 5'd1), 1'b1, 1'b1);
        step();
        check("flush_over_stall_ex", 32'(exVec()), 32'd0);
        check("flush_over_stall_mem", 32'(bus.mem_memread_o), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        step();
        step();

        // JAL through WB
        drive(mk(6'd3, 5'd0, 5'd0), 1'b1, 1'b0);
        step();
        check("jal_ex", 32'(exVec()), 32'(11'b000_0_10_0_00_1_0));
        drive(32'h0, 1'b0, 1'b0);
        step();
        step();
        check("jal_wb", 32'({bus.wb_regwrite_o, bus.wb_memtoreg_o}), 32'(3'b1_10));

        // Illegal opcode 7: only ex_illegal_o set
        drive(mk(6'd7, 5'd0, 5'd0), 1'b1, 1'b0);
        step();
        check("illegal_op7", 32'(allVec()), 32'(18'b0_000_0_00_0_00_0_1_0_0_0_00));
        drive(32'h0, 1'b0, 1'b0);
        step();
        step();

        // Decode table sweep
        for (int i = 0; i < 12; i++) begin
            drive(mk(tblOp[i], 5'd0, 5'd0), 1'b1, 1'b0);
            step();
            check($sformatf("decode_op%0d", tblOp[i]), 32'(exVec()), 32'(tblExp[i]));
        end
        drive(32'h0, 1'b0, 1'b0);
        step();
        check("sw_mem_write", 32'(bus.mem_memwrite_o), 32'd1);
        step();
        step();

        // Asynchronous reset with lw in MEM
        drive(mk(6'd35, 5'd1, 5'd4), 1'b1, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        check("mid_reset_pre", 32'(bus.mem_memread_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_reset_memread", 32'(bus.mem_memread_o), 32'd0);
        check("mid_reset_all", 32'(allVec()), 32'd0);
        drive(mk(6'd35, 5'd1, 5'd4), 1'b1, 1'b0);
        #2;
        rst_i = 1'b1;
        step();
        check("post_reset_load", 32'(exVec()), 32'(11'b011_1_00_0_00_0_0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_decoder.md
PIPE_CTRL_DECODER -- requirements
Module: pipe_ctrl_decoder

Interface
REQ-001 Parameter: ALU_OP_W, default 3, width of ALU op fields; values below 3 are illegal; opcodes are zero-extended.
REQ-002 Parameter: HAZARD_EN, default 1; 1 enables load-use detection; 0 ties stall_o to 0.
REQ-003 Port: clk_i  in  1  single clock; all flops rising-edge.
REQ-004 Port: rst_i  in  1  reset; asynchronous assert, active-low.
REQ-005 Port: instr_i  in  32  instruction in ID; op=[31:26], rs=[25:21], rt=[20:16].
REQ-006 Port: id_valid_i  in  1  instr_i holds a real instruction.
REQ-007 Port: flush_i  in  1  kill the ID and EX instructions (taken branch or jump).
REQ-008 Port: stall_o  out  1  combinational load-use stall request to PC and IF/ID.
REQ-009 Port: ex_alu_op_o  out  ALU_OP_W  ALU op in EX.
REQ-010 Ports: ex_alusrc_o  out  1  immediate operand; ex_regdst_o  out  2  00 rt, 01 rd, 10 $31.
REQ-011 Ports: ex_branch_o  out  1; ex_branch_type_o  out  2  00 beq, 01 bne, 10 ble, 11 bltz; ex_jump_o  out  1.
REQ-012 Ports: ex_illegal_o  out  1  EX holds an undefined opcode.
REQ-013 Ports: mem_memread_o  out  1; mem_memwrite_o  out  1  memory controls in MEM.
REQ-014 Ports: wb_regwrite_o  out  1; wb_memtoreg_o  out  2  00 ALU, 01 memory, 10 PC+4.

Function
REQ-015 Decode SHALL be combinational from op into one bundle: RW, ALU, SRC, DST, BR, BT, J, MR, MW, M2R, ILL.
REQ-016 Bundle per op: 0 R-type: RW=1, ALU=000, DST=01.
REQ-017 Bundle per op: 1 bltz: BR=1, BT=11, ALU=010. 4 beq: BR=1, BT=00, ALU=001. 5 bne: BR=1, BT=01, ALU=001. 6 ble: BR=1, BT=10, ALU=111.
REQ-018 Bundle per op: 2 J: J=1. 3 JAL: J=1, RW=1, DST=10, M2R=10.
REQ-019 Bundle per op: 8 addi: RW=1, SRC=1, ALU=011. 9 sltiu: RW=1, SRC=1, ALU=100. 13 ori: RW=1, SRC=1, ALU=101. 15 lui: RW=1, SRC=1, ALU=110.
REQ-020 Bundle per op: 35 lw: RW=1, SRC=1, ALU=011, MR=1, M2R=01. 43 sw: SRC=1, ALU=011, MW=1.
REQ-021 Every bundle field not listed in REQ-016 to REQ-020 SHALL be 0.
REQ-022 Any other opcode SHALL give an all-zero bundle with ILL=1; no latches.
REQ-023 Pipeline registers SHALL be ID/EX (full bundle plus rt), EX/MEM (MR, MW, RW, M2R) and MEM/WB (RW, M2R).
REQ-024 ex_* SHALL be valid 1 cycle after decode, mem_* after 2 cycles and wb_* after 3 cycles.
REQ-025 A bubble SHALL be an all-zero bundle; ID/EX SHALL load a bubble when id_valid_i=0.
REQ-026 Load-use: stall_o=1 iff HAZARD_EN, id_valid_i, ID/EX MR=1, ID/EX rt!=0, and ID/EX rt equals ID rs or ID rt.
REQ-027 While stall_o=1, ID/EX SHALL load a bubble; EX/MEM and MEM/WB SHALL advance normally.
REQ-028 flush_i=1 SHALL load bubbles into ID/EX and EX/MEM at the next edge, and SHALL take priority over stall_o.
REQ-029 A flushed or stalled instruction SHALL never assert MW or RW downstream.

Reset
REQ-030 Asserting rst_i low SHALL immediately clear all pipeline registers to bubbles, independent of clk_i.
REQ-031 During reset every output SHALL be 0, including stall_o.
REQ-032 Reset mid-operation SHALL discard all in-flight control; the first edge after release SHALL load ID/EX normally.

Verification
REQ-033 Scenario: op=35 with id_valid_i=1 at cycle 0 -> ex_alu_op_o=011 and ex_alusrc_o=1 at cycle 1; mem_memread_o=1 at cycle 2; wb_regwrite_o=1 and wb_memtoreg_o=01 at cycle 3.
REQ-034 Scenario: lw rt=5, then add with rs=5 in ID -> stall_o=1 for exactly one cycle; ex_* is a bubble in the next cycle; add then issues.
REQ-035 Scenario: lw rt=0, then a consumer of rs=0 -> stall_o stays 0.
REQ-036 Scenario: sw in ID and lw in EX, with flush_i=1 -> next cycle ex_* and mem_* are 0 and mem_memwrite_o never asserts.
REQ-037 Scenario: op=3 (JAL) -> ex_jump_o=1 and ex_regdst_o=10, then wb_memtoreg_o=10 with wb_regwrite_o=1. Op=7 -> ex_illegal_o=1 with all other outputs 0.
REQ-038 Scenario: rst_i driven low between clock edges with lw in MEM -> mem_memread_o drops to 0 before the next edge.
